// File: rtl/cache_bus_burst_responder_if.sv
// Cache-side line-transfer signals and AHB-Lite master bus signals for the burst responder.
// The master modport is the responder's view; slave is the cache/bus environment's view.
interface cache_bus_burst_responder_if #(
  parameter int unsigned PA_BITS = 32,
  parameter int unsigned LINELEN = 256,
  parameter int unsigned AHBW    = 64,
  parameter int unsigned LOGBWPL = 2
);
  logic [1:0]         CacheBusRW;
  logic [PA_BITS-1:0] CacheBusAdr;
  logic [AHBW-1:0]    CacheWriteBeat;
  logic               CacheBusAck;
  logic               SelBusBeat;
  logic [LOGBWPL-1:0] BeatCount;
  logic [LINELEN-1:0] FetchBuffer;

  logic [PA_BITS-1:0] HADDR;
  logic [1:0]         HTRANS;
  logic               HWRITE;
  logic [2:0]         HBURST;
  logic [2:0]         HSIZE;
  logic [AHBW-1:0]    HWDATA;
  logic [AHBW-1:0]    HRDATA;
  logic               HREADY;

  modport master (
    input  CacheBusRW, CacheBusAdr, CacheWriteBeat, HRDATA, HREADY,
    output CacheBusAck, SelBusBeat, BeatCount, FetchBuffer,
           HADDR, HTRANS, HWRITE, HBURST, HSIZE, HWDATA
  );

  modport slave (
    output CacheBusRW, CacheBusAdr, CacheWriteBeat, HRDATA, HREADY,
    input  CacheBusAck, SelBusBeat, BeatCount, FetchBuffer,
           HADDR, HTRANS, HWRITE, HBURST, HSIZE, HWDATA
  );
endinterface

// File: rtl/cache_bus_burst_responder.sv
// Runs one cache line fetch or write-back as an AHB-Lite incrementing burst,
// assembling fetched beats into FetchBuffer and acking the cache on completion.
module cache_bus_burst_responder #(
  parameter int unsigned PA_BITS = 32,
  parameter int unsigned LINELEN = 256,
  parameter int unsigned AHBW    = 64,
  parameter int unsigned LOGBWPL = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  cache_bus_burst_responder_if.master   bus
);

  localparam int unsigned BEATS      = LINELEN / AHBW;
  localparam int unsigned BYTE_SHIFT = $clog2(AHBW / 8);
  localparam logic [PA_BITS-1:0] OFFSET_MASK = PA_BITS'((LINELEN / 8) - 1);
  localparam logic [2:0] BURST_CODE = (BEATS == 4)  ? 3'b011 :
                                      (BEATS == 8)  ? 3'b101 :
                                      (BEATS == 16) ? 3'b111 : 3'b001;
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {IDLE, BURST, LASTDATA, ACK} state_t;

  state_t             r_state, w_next_state;
  logic [PA_BITS-1:0] r_line_adr;
  logic [LOGBWPL-1:0] r_adr_count;
  logic [LOGBWPL-1:0] r_beat_count;
  logic               r_dphase;
  logic               r_hwrite;
  logic [LINELEN-1:0] r_fetch_buf;

  logic               w_req;
  logic               w_beat_done;
  logic [1:0]         w_htrans;
  logic               w_ack;
  logic               w_sel;

  assign w_req       = (bus.CacheBusRW != 2'b00);
  // A data phase completes in BURST or LASTDATA whenever the previous address phase was accepted.
  assign w_beat_done = r_dphase && bus.HREADY && (r_state == BURST || r_state == LASTDATA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (w_req) w_next_state = BURST;
      BURST:    if (bus.HREADY && r_adr_count == LOGBWPL'(BEATS - 1)) w_next_state = LASTDATA;
      LASTDATA: if (bus.HREADY) w_next_state = ACK;
      ACK:      w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_htrans = TRANS_IDLE;
    w_ack    = 1'b0;
    w_sel    = 1'b1;
    case (r_state)
      IDLE:    w_sel    = 1'b0;
      BURST:   w_htrans = (r_adr_count == '0) ? TRANS_NONSEQ : TRANS_SEQ;
      ACK:     w_ack    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_line_adr   <= '0;
      r_adr_count  <= '0;
      r_beat_count <= '0;
      r_dphase     <= 1'b0;
      r_hwrite     <= 1'b0;
      r_fetch_buf  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_line_adr   <= bus.CacheBusAdr & ~OFFSET_MASK;
            r_hwrite     <= bus.CacheBusRW[0];
            r_adr_count  <= '0;
            r_beat_count <= '0;
            r_dphase     <= 1'b0;
          end
        end
        BURST: begin
          if (bus.HREADY) begin
            r_adr_count <= r_adr_count + LOGBWPL'(1);
            r_dphase    <= 1'b1;
          end
        end
        LASTDATA: begin
          if (bus.HREADY) r_dphase <= 1'b0;
        end
        default: ;
      endcase

      if (w_beat_done) begin
        r_beat_count <= r_beat_count + LOGBWPL'(1);
        if (!r_hwrite) begin
          for (int unsigned i = 0; i < BEATS; i++) begin
            if (r_beat_count == LOGBWPL'(i)) r_fetch_buf[i*AHBW +: AHBW] <= bus.HRDATA;
          end
        end
      end else if (r_state == ACK) begin
        r_beat_count <= '0;
      end
    end
  end

  assign bus.HADDR       = r_line_adr + (PA_BITS'(r_adr_count) << BYTE_SHIFT);
  assign bus.HTRANS      = w_htrans;
  assign bus.HWRITE      = r_hwrite;
  assign bus.HBURST      = BURST_CODE;
  assign bus.HSIZE       = 3'(BYTE_SHIFT);
  assign bus.HWDATA      = bus.CacheWriteBeat;
  assign bus.CacheBusAck = w_ack;
  assign bus.SelBusBeat  = w_sel;
  assign bus.BeatCount   = r_beat_count;
  assign bus.FetchBuffer = r_fetch_buf;

endmodule

// File: tb/tb_cache_bus_burst_responder.sv
// Directed bench for cache_bus_burst_responder: fetch, write-back, wait states,
// back-to-back requests, mid-burst reset and unaligned request address.
module tb_cache_bus_burst_responder;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  cache_bus_burst_responder_if #(.PA_BITS(32), .LINELEN(256), .AHBW(64), .LOGBWPL(2)) bus ();

  cache_bus_burst_responder #(.PA_BITS(32), .LINELEN(256), .AHBW(64), .LOGBWPL(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Cache model: supplies write-back word 0xA0 + selected beat.
  assign bus.CacheWriteBeat = 64'h00A0 + 64'(bus.BeatCount);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle expectations of an uninterrupted 4-beat line transfer, cycle 0 = request cycle.
  localparam logic [1:0]  EXP_TRANS [7] = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
  localparam logic [31:0] EXP_OFS   [7] = '{32'h0, 32'h0, 32'h8, 32'h10, 32'h18, 32'h0, 32'h0};
  localparam logic [1:0]  EXP_BC    [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  localparam logic        EXP_ACK   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic        EXP_SEL   [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic [63:0] EXP_WD    [7] = '{64'h0, 64'h0, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'h0};

  localparam logic [63:0] D1 = 64'h1111_1111_1111_1111, D2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] D3 = 64'h3333_3333_3333_3333, D4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] D5 = 64'h5555_5555_5555_5555, D6 = 64'h6666_6666_6666_6666;
  localparam logic [63:0] D7 = 64'h7777_7777_7777_7777, D8 = 64'h8888_8888_8888_8888;
  localparam logic [63:0] W0 = 64'h0123_4567_89AB_CDEF, W1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] W2 = 64'h0F0F_0F0F_0F0F_0F0F, W3 = 64'hF0F0_F0F0_F0F0_F0F0;
  localparam logic [63:0] F0 = 64'hAAAA_0000_0000_0001, F1 = 64'hAAAA_0000_0000_0002;
  localparam logic [63:0] F2 = 64'hAAAA_0000_0000_0003, F3 = 64'hAAAA_0000_0000_0004;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then check bus outputs mid-cycle.
  task automatic cyc(input string tag, input logic [1:0] rw, input logic [31:0] adr,
                     input logic rdy, input logic [63:0] rd, input logic [1:0] et,
                     input logic [31:0] ea, input logic [1:0] eb, input logic ek);
    @(posedge clk); #1;
    bus.CacheBusRW  = rw;
    bus.CacheBusAdr = adr;
    bus.HREADY      = rdy;
    bus.HRDATA      = rd;
    @(negedge clk);
    check({tag, ".htrans"}, 256'(bus.HTRANS), 256'(et));
    if (et != 2'b00) check({tag, ".haddr"}, 256'(bus.HADDR), 256'(ea));
    check({tag, ".beat"}, 256'(bus.BeatCount), 256'(eb));
    check({tag, ".ack"}, 256'(bus.CacheBusAck), 256'(ek));
  endtask

  task automatic line_xfer(input string tag, input logic [1:0] rw, input logic [31:0] adr,
                           input logic [31:0] base, input logic [63:0] d0, input logic [63:0] d1,
                           input logic [63:0] d2, input logic [63:0] d3, input logic [255:0] exp_fb);
    logic [63:0] rd;
    for (int c = 0; c < 7; c++) begin
      case (c)
        2:       rd = d0;
        3:       rd = d1;
        4:       rd = d2;
        5:       rd = d3;
        default: rd = JUNK;
      endcase
      cyc($sformatf("%s.c%0d", tag, c), (c == 0) ? rw : 2'b00, adr, 1'b1, rd,
          EXP_TRANS[c], base + EXP_OFS[c], EXP_BC[c], EXP_ACK[c]);
      check($sformatf("%s.c%0d.sel", tag, c), 256'(bus.SelBusBeat), 256'(EXP_SEL[c]));
      if (c >= 1) check($sformatf("%s.c%0d.hwrite", tag, c), 256'(bus.HWRITE), 256'(rw[0]));
      if (rw == 2'b01 && c >= 2 && c <= 5)
        check($sformatf("%s.c%0d.hwdata", tag, c), 256'(bus.HWDATA), 256'(EXP_WD[c]));
      if (c == 6) check($sformatf("%s.fetchbuf", tag), bus.FetchBuffer, exp_fb);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    bus.CacheBusRW  = 2'b00;
    bus.CacheBusAdr = '0;
    bus.HRDATA      = '0;
    bus.HREADY      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.htrans", 256'(bus.HTRANS), 256'(2'b00));
    check("rst.ack", 256'(bus.CacheBusAck), 256'(1'b0));
    check("rst.sel", 256'(bus.SelBusBeat), 256'(1'b0));
    check("rst.beat", 256'(bus.BeatCount), 256'(2'd0));
    check("rst.fetchbuf", bus.FetchBuffer, 256'(0));
    check("rst.hwrite", 256'(bus.HWRITE), 256'(1'b0));
    check("rst.hburst", 256'(bus.HBURST), 256'(3'b011));
    check("rst.hsize", 256'(bus.HSIZE), 256'(3'd3));
    @(posedge clk); #1;
    reset = 1'b0;

    line_xfer("fetch1", 2'b10, 32'h8000_0040, 32'h8000_0040, D1, D2, D3, D4, {D4, D3, D2, D1});
    cyc("fetch1.c7", 2'b00, 32'h0, 1'b1, JUNK, 2'b00, 32'h0, 2'd0, 1'b0);
    check("fetch1.c7.sel", 256'(bus.SelBusBeat), 256'(1'b0));
    check("fetch1.c7.hold", bus.FetchBuffer, {D4, D3, D2, D1});

    // Write-back followed immediately by a fetch presented in the cycle after its ack.
    line_xfer("wb", 2'b01, 32'h8000_1000, 32'h8000_1000, JUNK, JUNK, JUNK, JUNK, {D4, D3, D2, D1});
    line_xfer("b2b", 2'b10, 32'h8000_0080, 32'h8000_0080, D5, D6, D7, D8, {D8, D7, D6, D5});

    // Three wait states while beat 2 is in its address phase.
    cyc("ws.c0", 2'b10, 32'h8000_0100, 1'b1, JUNK, 2'b00, 32'h0, 2'd0, 1'b0);
    cyc("ws.c1", 2'b00, 32'h8000_0100, 1'b1, JUNK, 2'b10, 32'h8000_0100, 2'd0, 1'b0);
    cyc("ws.c2", 2'b00, 32'h8000_0100, 1'b1, W0,   2'b11, 32'h8000_0108, 2'd0, 1'b0);
    cyc("ws.c3", 2'b00, 32'h8000_0100, 1'b0, JUNK, 2'b11, 32'h8000_0110, 2'd1, 1'b0);
    cyc("ws.c4", 2'b10, 32'h8000_0100, 1'b0, JUNK, 2'b11, 32'h8000_0110, 2'd1, 1'b0);
    cyc("ws.c5", 2'b01, 32'h8000_0100, 1'b0, JUNK, 2'b11, 32'h8000_0110, 2'd1, 1'b0);
    cyc("ws.c6", 2'b00, 32'h8000_0100, 1'b1, W1,   2'b11, 32'h8000_0110, 2'd1, 1'b0);
    cyc("ws.c7", 2'b00, 32'h8000_0100, 1'b1, W2,   2'b11, 32'h8000_0118, 2'd2, 1'b0);
    cyc("ws.c8", 2'b00, 32'h8000_0100, 1'b1, W3,   2'b00, 32'h0, 2'd3, 1'b0);
    cyc("ws.c9", 2'b00, 32'h8000_0100, 1'b1, JUNK, 2'b00, 32'h0, 2'd0, 1'b1);
    check("ws.fetchbuf", bus.FetchBuffer, {W3, W2, W1, W0});
    cyc("ws.c10", 2'b00, 32'h8000_0100, 1'b1, JUNK, 2'b00, 32'h0, 2'd0, 1'b0);

    // Reset arrives in the cycle after beat 1's data phase.
    cyc("mr.c0", 2'b10, 32'h8000_0200, 1'b1, JUNK, 2'b00, 32'h0, 2'd0, 1'b0);
    cyc("mr.c1", 2'b00, 32'h8000_0200, 1'b1, JUNK, 2'b10, 32'h8000_0200, 2'd0, 1'b0);
    cyc("mr.c2", 2'b00, 32'h8000_0200, 1'b1, D1,   2'b11, 32'h8000_0208, 2'd0, 1'b0);
    cyc("mr.c3", 2'b00, 32'h8000_0200, 1'b1, D2,   2'b11, 32'h8000_0210, 2'd1, 1'b0);
    @(posedge clk); #1;
    bus.HRDATA = D3;
    reset = 1'b1;
    #1;
    check("mr.htrans", 256'(bus.HTRANS), 256'(2'b00));
    check("mr.sel", 256'(bus.SelBusBeat), 256'(1'b0));
    check("mr.ack", 256'(bus.CacheBusAck), 256'(1'b0));
    check("mr.beat", 256'(bus.BeatCount), 256'(2'd0));
    check("mr.fetchbuf", bus.FetchBuffer, 256'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mr.post.ack", 256'(bus.CacheBusAck), 256'(1'b0));
    check("mr.post.sel", 256'(bus.SelBusBeat), 256'(1'b0));

    // Fetch after reset from an unaligned address; burst starts at the line base.
    line_xfer("unal", 2'b10, 32'h8000_0047, 32'h8000_0040, F0, F1, F2, F3, {F3, F2, F1, F0});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
